// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one functional unit per cycle onto the common data bus.
// The grant and tag are taken in cycle t, and the winner's registered result
// is broadcast in cycle t+1.
// Optional feature: define CDB_ARB_RR_EN for round-robin arbitration.
// When it is undefined, the arbiter uses fixed priority and the lowest index wins.
module cdb_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ROB_WIDTH  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ*ROB_WIDTH-1:0]  req_tag,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic                        cdb_valid,
   output logic [ROB_WIDTH-1:0]        cdb_tag,
   output logic [DATA_WIDTH-1:0]       cdb_data,
   output logic [15:0]                 grant_count
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Handshake: unit i dispatches in the cycle where req_valid[i] && req_ready[i].
   // req_ready depends only on req_valid, reset and arbitration state, never on
   // req_data. Units must not form req_valid from req_ready.

   logic [ROB_WIDTH-1:0]  tag_arr  [N_REQ];
   logic [DATA_WIDTH-1:0] data_arr [N_REQ];
   logic [IDX_W-1:0]      win;
   logic                  any_grant;
   logic                  refused;
   logic                  vld_q;
   logic [IDX_W-1:0]      sel_q;
   logic [ROB_WIDTH-1:0]  tag_q;

   // Unpack the flat per-unit tag and data buses into arrays.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         tag_arr[i]  = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
         data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef CDB_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr;
   int               idx;

   // Round-robin search begins at rr_ptr and wraps modulo N_REQ.
   always_comb begin
      win       = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!any_grant && req_valid[idx]) begin
            win       = IDX_W'(idx);
            any_grant = 1'b1;
         end
      end
      if (reset) begin
         any_grant = 1'b0;
      end
   end

   // After a grant to w, the pointer moves to w+1 so that w becomes lowest priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
   end
`else
   // Fixed priority: the scan runs from high to low, so the lowest asserted index wins.
   always_comb begin
      win       = '0;
      any_grant = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            win       = IDX_W'(k);
            any_grant = 1'b1;
         end
      end
      if (reset) begin
         any_grant = 1'b0;
      end
   end
`endif

   // Generate the one-hot grant. It is all zero when nothing is requested or during reset.
   always_comb begin
      req_ready = '0;
      if (any_grant) begin
         req_ready[win] = 1'b1;
      end
      refused = |(req_valid & ~req_ready);
   end

   // Stage register: capture the winner and its tag, and mark the next cycle valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         sel_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= any_grant;
         if (any_grant) begin
            sel_q <= win;
            tag_q <= tag_arr[win];
         end
      end
   end

   // Debug counter of cycles in which some requester was turned away; it saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_count <= '0;
      end else if (refused && grant_count != 16'hFFFF) begin
         grant_count <= grant_count + 16'd1;
      end
   end

   // Broadcast. A grant made just before reset is suppressed while reset is high.
   always_comb begin
      cdb_valid = vld_q & ~reset;
      cdb_tag   = tag_q;
      cdb_data  = cdb_valid ? data_arr[sel_q] : '0;
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter. It works in fixed-priority mode by default
// and in round-robin mode when CDB_ARB_RR_EN is defined.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int RW = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*RW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic            cdb_valid;
   logic [RW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [15:0]     grant_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0]  cont_ready [4];
   logic [RW-1:0] cont_tag   [4];
   logic [N-1:0]  wrap_ready;

   // clock
   always #5 clk = ~clk;

   cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_tag     (req_tag),
      .req_data    (req_data),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .grant_count (grant_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      req_valid = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_tag(input int i, input logic [RW-1:0] t);
      req_tag[i*RW +: RW] = t;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] d);
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
`ifdef CDB_ARB_RR_EN
      cont_ready = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      cont_tag   = '{4'd8, 4'd9, 4'd11, 4'd8};
      wrap_ready = 4'b0010;
`else
      cont_ready = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
      cont_tag   = '{4'd8, 4'd8, 4'd8, 4'd8};
      wrap_ready = 4'b0001;
`endif
      // Reset state, checked with every unit requesting.
      reset     = 1'b1;
      req_valid = '1;
      req_tag   = '0;
      req_data  = '0;
      #1;
      check("rst_ready", 32'(req_ready), 32'h0);
      tick();
      check("rst_valid", 32'(cdb_valid), 32'h0);
      check("rst_gc", 32'(grant_count), 32'h0);
      check("rst_ready2", 32'(req_ready), 32'h0);
      do_reset();

      // Single request.
      req_valid = 4'b0100;
      set_tag(2, 4'd5);
      #1;
      check("single_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      set_data(2, 32'hDEADBEEF);
      #1;
      check("single_valid", 32'(cdb_valid), 32'h1);
      check("single_tag", 32'(cdb_tag), 32'h5);
      check("single_data", cdb_data, 32'hDEADBEEF);
      tick();
      check("single_idle", 32'(cdb_valid), 32'h0);
      check("single_gc", 32'(grant_count), 32'h0);

      // Contention with 4'b1011 held. Unit i has tag i+8.
      do_reset();
      for (int i = 0; i < N; i++) set_tag(i, RW'(i + 8));
      req_valid = 4'b1011;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("cont_ready%0d", c), 32'(req_ready), 32'(cont_ready[c]));
         tick();
         check($sformatf("cont_tag%0d", c), 32'(cdb_tag), 32'(cont_tag[c]));
         check($sformatf("cont_gc%0d", c), 32'(grant_count), 32'(c + 1));
      end
      req_valid = '0;

      // Back-to-back grants to unit 1.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_valid = 4'b0010;
         set_tag(1, RW'(k + 1));
         set_data(1, DW'(10 * k));
         #1;
         check($sformatf("b2b_ready%0d", k), 32'(req_ready), 32'h2);
         if (k > 0) begin
            check($sformatf("b2b_valid%0d", k), 32'(cdb_valid), 32'h1);
            check($sformatf("b2b_tag%0d", k), 32'(cdb_tag), 32'(k));
            check($sformatf("b2b_data%0d", k), cdb_data, 32'(10 * k));
         end
         tick();
      end
      req_valid = '0;
      set_data(1, 32'd40);
      #1;
      check("b2b_valid4", 32'(cdb_valid), 32'h1);
      check("b2b_tag4", 32'(cdb_tag), 32'h4);
      check("b2b_data4", cdb_data, 32'd40);
      tick();
      check("b2b_end", 32'(cdb_valid), 32'h0);

      // Wrap-around: the grant to 2 moves the pointer to 3, then 0 wins, then the full set is arbitrated.
      do_reset();
      req_valid = 4'b0100;
      #1;
      check("wrap_a", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0001;
      #1;
      check("wrap_b", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b1111;
      #1;
      check("wrap_c", 32'(req_ready), 32'(wrap_ready));
      tick();
      req_valid = '0;

      // Reset arriving in the middle of operation.
      do_reset();
      req_valid = 4'b1111;
      tick();
      check("mid_gc_pre", 32'(grant_count), 32'h1);
      req_valid = 4'b0100;
      set_tag(2, 4'd7);
      set_data(2, 32'h12345678);
      #1;
      check("mid_ready", 32'(req_ready), 32'h4);
      tick();
      reset = 1'b1;
      #1;
      check("mid_valid_t1", 32'(cdb_valid), 32'h0);
      check("mid_ready_rst", 32'(req_ready), 32'h0);
      check("mid_data_t1", cdb_data, 32'h0);
      tick();
      reset     = 1'b0;
      req_valid = '0;
      #1;
      check("mid_valid_t2", 32'(cdb_valid), 32'h0);
      check("mid_gc", 32'(grant_count), 32'h0);

      // Idle with non-zero data on every unit.
      req_data = '1;
      for (int c = 0; c < 10; c++) begin
         check($sformatf("idle_ready%0d", c), 32'(req_ready), 32'h0);
         check($sformatf("idle_valid%0d", c), 32'(cdb_valid), 32'h0);
         check($sformatf("idle_data%0d", c), cdb_data, 32'h0);
         check($sformatf("idle_gc%0d", c), 32'(grant_count), 32'h0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates between functional units that want the common data bus (CDB) and drives one CDB broadcast per cycle. The load unit is one of these units, through its gpr_cdb_req/fpr_cdb_req handshake.
- One instance serves the GPR CDB and one serves the FPR CDB. Its outputs feed the register files, the ROB and every reservation station's tag_match logic.
- Grant is issued in cycle t. The tag is captured in cycle t. The data is taken from the granted unit's result register in cycle t+1, which matches units whose result is registered one cycle after dispatch.

Parameters:
- N_REQ, 4, number of requesting units; index 0 is highest priority in fixed mode.
- ROB_WIDTH, 4, tag width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  unit i has a result ready to dispatch.
- req_ready  out  N_REQ  one-hot grant; unit i dispatches when req_valid[i] and req_ready[i] are both high.
- req_tag  in  N_REQ*ROB_WIDTH  tag of unit i, slice i; sampled in the grant cycle.
- req_data  in  N_REQ*DATA_WIDTH  result of unit i, slice i; sampled the cycle after grant.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  ROB_WIDTH  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast data.
- grant_count  out  16  saturating count of cycles in which some req_valid was refused; debug only.

Behaviour:
- Grant logic is combinational:
  - req_ready is zero when no req_valid is set.
  - Otherwise exactly one bit of req_ready is set, and only at a position whose req_valid is set.
  - req_ready[i] must never be combinationally dependent on req_data.
  - Units must not derive req_valid from req_ready; there must be no combinational loop.
- Stage register, updated on the clock edge when a grant occurs:
  - sel_q <= winner index.
  - tag_q <= req_tag[winner].
  - vld_q <= 1.
  - With no grant, vld_q <= 0; sel_q and tag_q hold their values.
- Outputs:
  - cdb_valid = vld_q.
  - cdb_tag = tag_q.
  - cdb_data = req_data slice sel_q, combinational, in cycle t+1.
  - cdb_data is don't-care when cdb_valid = 0; drive 0 in that case.
- Latency: grant in cycle t, broadcast in cycle t+1. Back-to-back grants give a broadcast every cycle.
- Throughput: one result per cycle, with no bubble between consecutive grants to the same or different units.
- A unit must not change its result register during the cycle after its grant. The same unit may be granted again in t+1, because its new result lands in t+2.
- grant_count increments when at least 2 req_valid bits are set (one loses), or when exactly 1 is set and it is masked; it saturates at 16'hFFFF.
- Reset, synchronous:
  - vld_q = 0, sel_q = 0, tag_q = 0, rr_ptr = 0, grant_count = 0.
  - During the reset cycle req_ready = 0. No grant is issued while reset is high.
  - A grant issued in the cycle before reset asserts is dropped: cdb_valid = 0 in the reset cycle's successor.
- No buffering. A refused unit keeps req_valid high; the arbiter needs no other memory of pending requests.

Optional Feature:
- Macro CDB_ARB_RR_EN.
- When defined: round-robin arbitration.
  - rr_ptr (log2 N_REQ bits) gives the highest-priority index. The search runs rr_ptr, rr_ptr+1, ... with wrap-around modulo N_REQ.
  - On a grant to index w, rr_ptr <= (w+1) mod N_REQ; with no grant it holds.
- When undefined: fixed priority, where the lowest asserted index wins.
  - rr_ptr is not implemented.
  - Starvation of high indices is acceptable in this mode.

Test Plan:
- Single request: after reset, req_valid = 4'b0100, tag2 = 5 in cycle t, data2 = 32'hDEADBEEF in t+1 -> req_ready = 4'b0100 in t; cdb_valid = 1, cdb_tag = 5, cdb_data = 32'hDEADBEEF in t+1; cdb_valid = 0 in t+2 if req_valid is dropped.
- Contention, fixed mode: req_valid = 4'b1011 held for 3 cycles -> grants 0, 0, 0; grant_count = 3. With CDB_ARB_RR_EN defined -> grants 0, 1, 3, then 0.
- Back-to-back: unit 1 valid for 4 cycles with tags 1, 2, 3, 4 and data 10, 20, 30, 40 each one cycle later -> cdb_valid high for 4 consecutive cycles carrying pairs (1,10) (2,20) (3,30) (4,40).
- Wrap-around, RR mode: rr_ptr = 3, req_valid = 4'b0001 -> grant 0, rr_ptr becomes 1. Then req_valid = 4'b1111 -> grant 1.
- Reset mid-operation: grant to unit 2 in cycle t with reset high in t+1 -> cdb_valid = 0 in t+1 and t+2, grant_count = 0, req_ready = 0 during the reset cycle.
- Idle: all req_valid low for 10 cycles -> req_ready = 0, cdb_valid = 0, cdb_data = 0, grant_count unchanged.
